// File: rtl/tcount_seq_checker_if.sv
// Sample/result bundle between a counter-under-test source and the sequence checker.
interface tcount_seq_checker_if #(
  parameter int WIDTH      = 3,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
);
  logic                  EN;
  logic [WIDTH-1:0]      CNT_IN;
  logic                  LOCKED;
  logic                  ERR;
  logic                  WRAP;
  logic [ERR_CNT_W-1:0]  ERR_COUNT;
  logic [WRAP_CNT_W-1:0] WRAP_COUNT;

  modport master (
    output EN, CNT_IN,
    input  LOCKED, ERR, WRAP, ERR_COUNT, WRAP_COUNT
  );

  modport slave (
    input  EN, CNT_IN,
    output LOCKED, ERR, WRAP, ERR_COUNT, WRAP_COUNT
  );
endinterface

// File: rtl/tcount_seq_checker.sv
// Sequence checker for a modulo-2^WIDTH counter: locks onto a valid up/down
// sequence, pulses ERR on mismatches and WRAP on wrap steps while locked.
module tcount_seq_checker #(
  parameter int WIDTH      = 3,
  parameter int DIR        = 0,
  parameter int LOCK_CNT   = 2,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input logic                  CLK,
  input logic                  RST_N,
  tcount_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_LOCKED
  } state_t;

  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_CNT);

  state_t                r_state,      w_state_nxt;
  logic [WIDTH-1:0]      r_prev,       w_prev_nxt;
  logic [3:0]            r_good_cnt,   w_good_cnt_nxt;
  logic                  r_err,        w_err_nxt;
  logic                  r_wrap,       w_wrap_nxt;
  logic [ERR_CNT_W-1:0]  r_err_count,  w_err_count_nxt;
  logic [WRAP_CNT_W-1:0] r_wrap_count, w_wrap_count_nxt;

  logic [WIDTH-1:0]      w_exp;
  logic                  w_good;
  logic                  w_wrap_step;
  logic [4:0]            w_good_inc;

  // Expected next value and step classification relative to the previous sample
  always_comb begin
    w_exp       = (DIR != 0) ? (r_prev - W_ONE) : (r_prev + W_ONE);
    w_good      = (bus.CNT_IN == w_exp);
    w_wrap_step = (DIR != 0) ? ((r_prev == '0) && (bus.CNT_IN == '1))
                             : ((r_prev == '1) && (bus.CNT_IN == '0));
    w_good_inc  = {1'b0, r_good_cnt} + 5'd1;
  end

  // Next-state and registered-output logic; everything holds when EN is low
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_good_cnt_nxt   = r_good_cnt;
    w_err_nxt        = 1'b0;
    w_wrap_nxt       = 1'b0;
    w_err_count_nxt  = r_err_count;
    w_wrap_count_nxt = r_wrap_count;

    if (bus.EN) begin
      w_prev_nxt = bus.CNT_IN;
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_SEARCH;
          w_good_cnt_nxt = '0;
        end
        S_SEARCH: begin
          if (w_good) begin
            if (w_good_inc == LOCK_TGT) begin
              w_state_nxt    = S_LOCKED;
              w_good_cnt_nxt = '0;
            end else begin
              w_good_cnt_nxt = w_good_inc[3:0];
            end
          end else begin
            w_good_cnt_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (w_good) begin
            if (w_wrap_step) begin
              w_wrap_nxt       = 1'b1;
              w_wrap_count_nxt = r_wrap_count + WRAP_CNT_W'(1);
            end
          end else begin
            w_err_nxt      = 1'b1;
            w_state_nxt    = S_SEARCH;
            w_good_cnt_nxt = '0;
            if (r_err_count != '1) begin
              w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_good_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_good_cnt   <= '0;
      r_err        <= 1'b0;
      r_wrap       <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_good_cnt   <= w_good_cnt_nxt;
      r_err        <= w_err_nxt;
      r_wrap       <= w_wrap_nxt;
      r_err_count  <= w_err_count_nxt;
      r_wrap_count <= w_wrap_count_nxt;
    end
  end

  assign bus.LOCKED     = (r_state == S_LOCKED);
  assign bus.ERR        = r_err;
  assign bus.WRAP       = r_wrap;
  assign bus.ERR_COUNT  = r_err_count;
  assign bus.WRAP_COUNT = r_wrap_count;

endmodule

// File: tb/tb_tcount_seq_checker.sv
// Directed bench for tcount_seq_checker: an up-counting instance (A) and a
// down-counting instance with a 2-bit error counter (B).
module tb_tcount_seq_checker;

  logic clk;
  logic rst_n;
  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  tcount_seq_checker_if #(.WIDTH(3), .ERR_CNT_W(8), .WRAP_CNT_W(8)) ifa ();
  tcount_seq_checker_if #(.WIDTH(3), .ERR_CNT_W(2), .WRAP_CNT_W(8)) ifb ();

  tcount_seq_checker #(.WIDTH(3), .DIR(0), .LOCK_CNT(2), .ERR_CNT_W(8), .WRAP_CNT_W(8)) u_a (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifa)
  );

  tcount_seq_checker #(.WIDTH(3), .DIR(1), .LOCK_CNT(2), .ERR_CNT_W(2), .WRAP_CNT_W(8)) u_b (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive instance A for one edge and sample #1 after it
  task automatic step_a(input logic en, input logic [2:0] v);
    @(negedge clk);
    ifa.EN     = en;
    ifa.CNT_IN = v;
    ifb.EN     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic en, input logic [2:0] v);
    @(negedge clk);
    ifb.EN     = en;
    ifb.CNT_IN = v;
    ifa.EN     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic lk, input logic er, input logic wr,
                       input logic [7:0] ec, input logic [7:0] wc);
    chk({tag, ".locked"}, 32'(ifa.LOCKED), 32'(lk));
    chk({tag, ".err"},    32'(ifa.ERR),    32'(er));
    chk({tag, ".wrap"},   32'(ifa.WRAP),   32'(wr));
    chk({tag, ".errcnt"}, 32'(ifa.ERR_COUNT),  32'(ec));
    chk({tag, ".wrapcnt"},32'(ifa.WRAP_COUNT), 32'(wc));
  endtask

  task automatic chk_b(input string tag, input logic lk, input logic er, input logic wr,
                       input logic [1:0] ec, input logic [7:0] wc);
    chk({tag, ".locked"}, 32'(ifb.LOCKED), 32'(lk));
    chk({tag, ".err"},    32'(ifb.ERR),    32'(er));
    chk({tag, ".wrap"},   32'(ifb.WRAP),   32'(wr));
    chk({tag, ".errcnt"}, 32'(ifb.ERR_COUNT),  32'(ec));
    chk({tag, ".wrapcnt"},32'(ifb.WRAP_COUNT), 32'(wc));
  endtask

  initial begin
    logic [2:0] p;
    logic [1:0] exp_ec;

    // T1: reset held for two cycles with inputs toggling
    rst_n      = 1'b0;
    ifa.EN     = 1'b1;
    ifa.CNT_IN = 3'd0;
    ifb.EN     = 1'b1;
    ifb.CNT_IN = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifa.CNT_IN = ifa.CNT_IN + 3'd1;
      ifb.CNT_IN = ifb.CNT_IN - 3'd1;
    end
    chk_a("t1_rst_a", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk_b("t1_rst_b", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    ifa.EN = 1'b0;
    ifb.EN = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_a("t1_rel_a", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // T2: lock after the third sample, one wrap pulse on 7 -> 0
    step_a(1'b1, 3'd0); chk_a("t2_s0", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step_a(1'b1, 3'd1); chk_a("t2_s1", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step_a(1'b1, 3'd2); chk_a("t2_s2", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int v = 3; v <= 7; v++) begin
      step_a(1'b1, 3'(v));
      chk_a("t2_run", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    end
    step_a(1'b1, 3'd0); chk_a("t2_wrap", 1'b1, 1'b0, 1'b1, 8'd0, 8'd1);
    step_a(1'b1, 3'd1); chk_a("t2_post", 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);

    // T3: skip 3 -> 5 while locked, relock on 6,7
    step_a(1'b1, 3'd2);
    step_a(1'b1, 3'd3); chk_a("t3_pre",  1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
    step_a(1'b1, 3'd5); chk_a("t3_skip", 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
    step_a(1'b1, 3'd6); chk_a("t3_r1",   1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    step_a(1'b1, 3'd7); chk_a("t3_r2",   1'b1, 1'b0, 1'b0, 8'd1, 8'd1);

    // T4: enable gap with junk on CNT_IN, then continue from 4 to 5
    step_a(1'b1, 3'd0); chk_a("t4_wrap", 1'b1, 1'b0, 1'b1, 8'd1, 8'd2);
    step_a(1'b1, 3'd1);
    step_a(1'b1, 3'd2);
    step_a(1'b1, 3'd3);
    step_a(1'b1, 3'd4);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 3'(i * 3 + 1));
      chk_a("t4_gap", 1'b1, 1'b0, 1'b0, 8'd1, 8'd2);
    end
    step_a(1'b1, 3'd5); chk_a("t4_resume", 1'b1, 1'b0, 1'b0, 8'd1, 8'd2);
    // Repeated value counts as a mismatch
    step_a(1'b1, 3'd5); chk_a("t4_repeat", 1'b0, 1'b1, 1'b0, 8'd2, 8'd2);
    step_a(1'b1, 3'd6); chk_a("t4_rl1", 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);
    step_a(1'b1, 3'd7); chk_a("t4_rl2", 1'b1, 1'b0, 1'b0, 8'd2, 8'd2);

    // T5: down direction, five mismatches with relock between, 2-bit saturation
    step_b(1'b1, 3'd7); chk_b("t5_s0", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    step_b(1'b1, 3'd6); chk_b("t5_s1", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    step_b(1'b1, 3'd5); chk_b("t5_lk", 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    p      = 3'd5;
    exp_ec = 2'd0;
    for (int i = 0; i < 5; i++) begin
      if (exp_ec != 2'd3) exp_ec = exp_ec + 2'd1;
      step_b(1'b1, p);
      chk_b("t5_bad", 1'b0, 1'b1, 1'b0, exp_ec, 8'd0);
      p = p - 3'd1;
      step_b(1'b1, p);
      chk_b("t5_rl1", 1'b0, 1'b0, 1'b0, exp_ec, 8'd0);
      p = p - 3'd1;
      step_b(1'b1, p);
      chk_b("t5_rl2", 1'b1, 1'b0, 1'b0, exp_ec, 8'd0);
    end
    // p is 3 here: 2,1,0 then the locked down-wrap to 7
    step_b(1'b1, 3'd2);
    step_b(1'b1, 3'd1);
    step_b(1'b1, 3'd0); chk_b("t5_pre_wrap", 1'b1, 1'b0, 1'b0, 2'd3, 8'd0);
    step_b(1'b1, 3'd7); chk_b("t5_wrap", 1'b1, 1'b0, 1'b1, 2'd3, 8'd1);

    // T6: asynchronous reset between edges while A is locked
    step_a(1'b1, 3'd0); chk_a("t6_pre", 1'b1, 1'b0, 1'b1, 8'd2, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("t6_async_a", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    chk_b("t6_async_b", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_a(1'b1, 3'd3); chk_a("t6_s0", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step_a(1'b1, 3'd4); chk_a("t6_s1", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step_a(1'b1, 3'd5); chk_a("t6_lk", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
